// File: rtl/exec_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_controller_pkg
// Description : Shared types for the 4-bit cpu core and its execution controller.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_controller_pkg;

    typedef enum logic [3:0] {
        NOP = 4'h0,
        LDI = 4'h1,
        ADD = 4'h2,
        SUB = 4'h3,
        LDA = 4'h4,
        STA = 4'h5,
        OUT = 4'h6,
        JZ  = 4'hE,
        JMP = 4'hF
    } opcode_t;

    typedef struct packed {
        logic       mode;
        logic [3:0] addr;
    } virt_addr_t;

    typedef struct packed {
        virt_addr_t virt_addr;
    } addr_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [3:0] imm;
    } data_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_LOAD = 3'd3,
        ST_CLR  = 3'd4
    } exec_state_t;

    typedef enum logic [1:0] {
        CMD_HALT = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_LOAD = 2'd3
    } exec_cmd_t;

    localparam int MEM_WORDS = 32;

    // CLR is an internal tail of LOAD and is reported as LOAD.
    function automatic logic [1:0] state_code(input exec_state_t s);
        return (s == ST_CLR) ? 2'd3 : s[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_controller_run_divider.sv
`default_nettype none
// ============================================================================
// Module      : run_divider
// Description : RUN-mode period counter; flags when the next cycle is a step.
// Revision    : 1.0 - initial release
// ============================================================================
module run_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] period_in,
    output logic             pulse_next
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;

    // pulse_next looks ahead one cycle so the step output can be registered.
    always_comb begin
        period_d = load ? period_in : period_q;
        cnt_d    = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == period_q) ? '0 : cnt_q + DIV_W'(1);
        end
        pulse_next = (cnt_d == period_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_controller.sv
`default_nettype none
// ============================================================================
// Module      : exec_controller
// Description : Program store, byte-stream loader and step pacing for the cpu.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_controller
    import exec_controller_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_arg,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  data_t            ld_data,
    input  logic             ld_last,
    input  addr_t            cpu_addr,
    output data_t            cpu_data,
    output logic             cpu_step,
    output logic             cpu_reset,
    output logic [1:0]       state,
    output logic             loop_halt
);

    exec_state_t state_q, state_d;
    logic        cpu_step_q, cpu_step_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        loop_halt_q, loop_halt_d;
    logic [4:0]  ld_ptr_q, ld_ptr_d;
    logic [7:0]  mem_q [MEM_WORDS];
    logic [7:0]  mem_d [MEM_WORDS];

    logic cmd_fire, ld_fire, self_jump, div_load, div_pulse_next;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign ld_ready  = (state_q == ST_LOAD);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign cpu_data  = data_t'(mem_q[cpu_addr]);

    assign cpu_step  = cpu_step_q;
    assign cpu_reset = cpu_reset_q;
    assign loop_halt = loop_halt_q;
    assign state     = state_code(state_q);

    // The core is parked when the instruction it is executing jumps to itself.
    assign self_jump = (state_q == ST_RUN) && cpu_step_q &&
                       (cpu_data.opcode == JMP) &&
                       (cpu_data.imm == cpu_addr.virt_addr.addr);

    run_divider #(.DIV_W(DIV_W)) u_run_divider (
        .clock      (clock),
        .reset      (reset),
        .en         (state_q == ST_RUN),
        .load       (div_load),
        .period_in  (cmd_arg),
        .pulse_next (div_pulse_next)
    );

    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        mem_d       = mem_q;
        div_load    = 1'b0;
        loop_halt_d = cmd_fire ? 1'b0 : loop_halt_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (cmd_fire) begin
                    case (exec_cmd_t'(cmd_op))
                        CMD_HALT: state_d = ST_IDLE;
                        CMD_RUN: begin
                            state_d  = ST_RUN;
                            div_load = 1'b1;
                        end
                        CMD_STEP: state_d = ST_STEP;
                        CMD_LOAD: begin
                            state_d  = ST_LOAD;
                            ld_ptr_d = '0;
                        end
                        default: state_d = state_q;
                    endcase
                end
                // Auto-halt overrides RUN/STEP requests, but a LOAD still proceeds.
                if (self_jump) begin
                    loop_halt_d = 1'b1;
                    if (!(cmd_fire && (exec_cmd_t'(cmd_op) == CMD_LOAD))) begin
                        state_d  = ST_IDLE;
                        div_load = 1'b0;
                    end
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_LOAD: begin
                if (ld_fire) begin
                    mem_d[ld_ptr_q] = ld_data;
                    ld_ptr_d        = ld_ptr_q + 5'd1;
                    if (ld_last || (ld_ptr_q == 5'd31)) begin
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cpu_step_d  = (state_d == ST_STEP) || ((state_d == ST_RUN) && div_pulse_next);
        cpu_reset_d = (state_d == ST_LOAD) || (state_d == ST_CLR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cpu_step_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            loop_halt_q <= 1'b0;
            ld_ptr_q    <= '0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cpu_step_q  <= cpu_step_d;
            cpu_reset_q <= cpu_reset_d;
            loop_halt_q <= loop_halt_d;
            ld_ptr_q    <= ld_ptr_d;
            mem_q       <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_controller
// Description : Directed self-checking bench for exec_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_controller;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic [4:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_step;
    logic        cpu_reset;
    logic [1:0]  state;
    logic        loop_halt;

    int checks = 0;
    int errors = 0;

    exec_controller #(.DIV_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_step  (cpu_step),
        .cpu_reset (cpu_reset),
        .state     (state),
        .loop_halt (loop_halt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present a command for one cycle; returns at the negedge of the first cycle after acceptance.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clock);
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
        checks++; if (cpu_step !== 1'b0)  begin errors++; $display("FAIL rst_cpu_step got %b exp 0", cpu_step); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (loop_halt !== 1'b0) begin errors++; $display("FAIL rst_loop_halt got %b exp 0", loop_halt); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rst_release_cpu_reset got %b exp 0", cpu_reset); end
    endtask

    task automatic test_load;
        do_cmd(2'd3, 16'd0);
        checks++; if (state !== 2'd3)     begin errors++; $display("FAIL load_state got %0d exp 3", state); end
        checks++; if (ld_ready !== 1'b1)  begin errors++; $display("FAIL load_ld_ready got %b exp 1", ld_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_cmd_ready got %b exp 0", cmd_ready); end
        send_byte(8'h31, 1'b0);
        send_byte(8'h52, 1'b0);
        send_byte(8'hF0, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL clr_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL clr_ld_ready got %b exp 0", ld_ready); end
        @(negedge clock);
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL load_done_state got %0d exp 0", state); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_done_cpu_reset got %b exp 0", cpu_reset); end
        cpu_addr = 5'd1; #1;
        checks++; if (cpu_data !== 8'h52) begin errors++; $display("FAIL load_mem1 got %h exp 52", cpu_data); end
        cpu_addr = 5'd0; #1;
        checks++; if (cpu_data !== 8'h31) begin errors++; $display("FAIL load_mem0 got %h exp 31", cpu_data); end
        cpu_addr = 5'd2; #1;
        checks++; if (cpu_data !== 8'hF0) begin errors++; $display("FAIL load_mem2 got %h exp f0", cpu_data); end
        cpu_addr = 5'd3; #1;
        checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL load_mem3 got %h exp 00", cpu_data); end
        @(negedge clock);
    endtask

    task automatic test_step;
        int pulses = 0;
        cpu_addr = 5'd0;
        for (int n = 0; n < 2; n++) begin
            do_cmd(2'd2, 16'd0);
            checks++; if (cpu_step !== 1'b1)  begin errors++; $display("FAIL step_pulse got %b exp 1", cpu_step); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL step_cmd_ready got %b exp 0", cmd_ready); end
            checks++; if (state !== 2'd2)     begin errors++; $display("FAIL step_state got %0d exp 2", state); end
            if (cpu_step === 1'b1) pulses++;
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                if (cpu_step === 1'b1) pulses++;
            end
            checks++; if (state !== 2'd0)     begin errors++; $display("FAIL step_back_idle got %0d exp 0", state); end
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL step_count got %0d exp 2", pulses); end
    endtask

    task automatic test_run;
        cpu_addr = 5'd0;
        do_cmd(2'd1, 16'd3);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (cpu_step !== ((k % 4) == 0)) begin
                errors++; $display("FAIL run_pulse cycle %0d got %b exp %b", k, cpu_step, ((k % 4) == 0));
            end
            if (k < 8) @(negedge clock);
        end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state got %0d exp 1", state); end
        do_cmd(2'd0, 16'd0);
        for (int k = 0; k < 10; k++) begin
            checks++; if (cpu_step !== 1'b0) begin errors++; $display("FAIL halt_no_pulse cycle %0d got %b exp 0", k, cpu_step); end
            @(negedge clock);
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL halt_state got %0d exp 0", state); end
    endtask

    task automatic test_selfjump;
        do_cmd(2'd3, 16'd0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'hF2, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clock);
        cpu_addr = 5'd2;
        do_cmd(2'd1, 16'd0);
        checks++; if (cpu_step !== 1'b1)  begin errors++; $display("FAIL sj_pulse got %b exp 1", cpu_step); end
        checks++; if (state !== 2'd1)     begin errors++; $display("FAIL sj_run_state got %0d exp 1", state); end
        @(negedge clock);
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL sj_idle got %0d exp 0", state); end
        checks++; if (loop_halt !== 1'b1) begin errors++; $display("FAIL sj_flag got %b exp 1", loop_halt); end
        checks++; if (cpu_step !== 1'b0)  begin errors++; $display("FAIL sj_no_pulse got %b exp 0", cpu_step); end
        repeat (3) @(negedge clock);
        checks++; if (loop_halt !== 1'b1) begin errors++; $display("FAIL sj_flag_sticky got %b exp 1", loop_halt); end
        cpu_addr = 5'd0;
        do_cmd(2'd1, 16'd0);
        checks++; if (loop_halt !== 1'b0) begin errors++; $display("FAIL sj_flag_clear got %b exp 0", loop_halt); end
        checks++; if (cpu_step !== 1'b1)  begin errors++; $display("FAIL sj_rerun_pulse got %b exp 1", cpu_step); end
        do_cmd(2'd0, 16'd0);
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL sj_halt got %0d exp 0", state); end
    endtask

    task automatic test_load32;
        do_cmd(2'd3, 16'd0);
        for (int i = 0; i < 32; i++) begin
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL l32_ready byte %0d got %b exp 1", i, ld_ready); end
            send_byte(8'h40 + 8'(i), 1'b0);
        end
        ld_data = 8'hAA;
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL l32_ready_drop got %b exp 0", ld_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL l32_clr_reset got %b exp 1", cpu_reset); end
        @(negedge clock);
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL l32_idle got %0d exp 0", state); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL l32_idle_ready got %b exp 0", ld_ready); end
        ld_valid = 1'b0;
        cpu_addr = 5'd0; #1;
        checks++; if (cpu_data !== 8'h40) begin errors++; $display("FAIL l32_mem0 got %h exp 40", cpu_data); end
        cpu_addr = 5'd16; #1;
        checks++; if (cpu_data !== 8'h50) begin errors++; $display("FAIL l32_mem16 got %h exp 50", cpu_data); end
        cpu_addr = 5'd31; #1;
        checks++; if (cpu_data !== 8'h5F) begin errors++; $display("FAIL l32_mem31 got %h exp 5f", cpu_data); end
        @(negedge clock);
    endtask

    task automatic test_reset_midload;
        do_cmd(2'd3, 16'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), 1'b0);
        ld_valid = 1'b1; ld_data = 8'h64;
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL mid_state got %0d exp 0", state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL mid_ld_ready got %b exp 0", ld_ready); end
        checks++; if (cpu_step !== 1'b0)  begin errors++; $display("FAIL mid_cpu_step got %b exp 0", cpu_step); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (loop_halt !== 1'b0) begin errors++; $display("FAIL mid_loop_halt got %b exp 0", loop_halt); end
        for (int a = 0; a < 32; a++) begin
            cpu_addr = 5'(a); #1;
            checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL mid_mem addr %0d got %h exp 00", a, cpu_data); end
        end
        ld_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_release got %b exp 0", cpu_reset); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_step;
        test_run;
        test_selfjump;
        test_load32;
        test_reset_midload;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_controller.md
# exec_controller

Execution controller for the 4-bit `cpu` core. It owns the 32-word program store, which is 2 banks × 16 words selected by `addr.virt_addr.mode` / `addr.virt_addr.addr`, and serves instructions combinationally to the core. It loads programs over a valid/ready byte stream while holding the core in reset, and paces execution with a per-instruction enable pulse in HALT, single-STEP or divided-RUN modes. It also halts automatically when the core parks on a self-jump.

## Interface
- `DIV_W`, default 16: width of the RUN divider period.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0 = HALT, 1 = RUN, 2 = STEP, 3 = LOAD.
- `cmd_arg` in DIV_W: RUN period, cycles between steps minus 1. Ignored for other ops.
- `ld_valid` in 1: load byte valid.
- `ld_ready` out 1: load byte accepted when both are high.
- `ld_data` in 8 (`data_t`): program word.
- `ld_last` in 1: final word of the program.
- `cpu_addr` in 5 (`addr_t`): fetch address from the core.
- `cpu_data` out 8 (`data_t`): instruction at `cpu_addr`.
- `cpu_step` out 1: one-cycle clock-enable pulse; the core executes one instruction per pulse.
- `cpu_reset` out 1: reset to the core.
- `state` out 2: 0 = IDLE, 1 = RUN, 2 = STEP, 3 = LOAD.
- `loop_halt` out 1: sticky flag, set on self-jump auto-halt.

## Operation
- Store: 32 × 8 registers, cleared to 0 by `reset`. Read is combinational: `cpu_data = mem[cpu_addr]`.
- FSM states: IDLE, RUN, STEP, LOAD, CLR.
- IDLE: `cpu_step`=0. Accepted commands:
  - HALT: stay in IDLE.
  - RUN: latch `period = cmd_arg`, clear `divcnt`, go to RUN.
  - STEP: go to STEP.
  - LOAD: clear `ld_ptr`, go to LOAD.
- RUN: `divcnt` increments each cycle. When `divcnt == period`, pulse `cpu_step` and wrap `divcnt` to 0. With `period=0` the pulse fires every cycle. Accepted commands:
  - HALT: go to IDLE.
  - STEP: go to STEP.
  - RUN: reload `period`, clear `divcnt`.
  - LOAD: go to LOAD.
- STEP: `cpu_step`=1 for exactly one cycle, then IDLE.
- LOAD: `cpu_reset`=1 and `ld_ready`=1.
  - Each accepted byte is written to `mem[ld_ptr]` and `ld_ptr` increments (5-bit).
  - After a byte with `ld_last`=1, or the byte written at `ld_ptr`=31, go to CLR. The pointer wraps at 31, so a 33rd byte is never accepted.
  - Words beyond the loaded length keep their previous contents.
- CLR: `cpu_reset`=1 for one cycle, then IDLE. The core always starts from address 0 after a load.
- Self-jump detect (RUN only): on a `cpu_step` cycle where `cpu_data.opcode == JMP` and `cpu_data.imm == cpu_addr.virt_addr.addr`:
  - go to IDLE;
  - set `loop_halt`.
  - The pulse still fires on that cycle.
- `loop_halt` clears on the next accepted command.
- `cmd_ready` = 1 in IDLE and RUN, 0 in STEP, LOAD and CLR.
- Simultaneous events: a command accepted on the same cycle as a RUN divider pulse still lets the pulse fire. A self-jump detect on that cycle takes priority over RUN/STEP but not over LOAD (LOAD wins).

## Timing
- Reset values:
  - `state`=IDLE, `cmd_ready`=1, `ld_ready`=0, `cpu_step`=0, `cpu_reset`=1, `loop_halt`=0.
  - `divcnt`=0, `period`=0, `ld_ptr`=0, store all zero.
- `cpu_reset` drops on the first clock after `reset` deasserts.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to the reset values above. Partially loaded words are lost because the store is cleared.
- Command latency: the new state takes effect the cycle after acceptance. For a RUN accepted at cycle t, the first `cpu_step` is at cycle t+1+period.
- The load path accepts at most one byte per cycle with zero bubble.
- All outputs except `cpu_data` and `cmd_ready`/`ld_ready` are registered. The ready signals decode `state`.

## Structure
- Shared package (`types.svh`):
  - `addr_t`, `data_t`, opcode enum (incl. `JMP`) — existing;
  - new `exec_state_t`, `exec_cmd_t` enums.
- Sub-module `run_divider`: DIV_W counter with load/clear, emits the pulse. Everything else stays in `exec_controller`.

## Test plan
- Load 3 bytes 0x31,0x52,0xF0 (last on 3rd) → `mem[0..2]` written, `cpu_reset` high through CLR, IDLE the cycle after; `cpu_data` at addr 1 = 0x52.
- STEP ×2 from IDLE → exactly two single-cycle `cpu_step` pulses, `cmd_ready` low on each STEP cycle.
- RUN arg=3 → pulses every 4th cycle, first at t+4. HALT after 2 pulses → no further pulses.
- Program with JMP to own address (e.g. 0xF2 at addr 2) in RUN arg=0 → one pulse with that fetch, then IDLE, `loop_halt`=1. Next RUN clears the flag.
- Load 32 bytes with no `ld_last` → `ld_ready` drops after byte 32, `mem[31]` written, no wrap overwrite of `mem[0]`.
- Assert `reset` mid-load at byte 5 → all outputs at reset values, store reads 0 everywhere.
